// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction fetch front end.
package mips_fetch_pkg;

    // Fetch sequencer states: issue request, wait for memory, hold word for decode.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0004;
    localparam logic [31:0] WORD_BYTES       = 32'd4;

endpackage

// File: rtl/instr_fetch_unit_pc_adder.sv
// Sequential-address adder: next word address after pc, wrapping at 2^32.
module instr_fetch_unit_pc_adder
    import mips_fetch_pkg::*;
(
    input  logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    assign pc_plus4 = pc + WORD_BYTES;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, reads instruction memory over a
// req/ack handshake, and hands each word to decode with valid/ready. The PC
// advances (sequentially or to a redirect target) only when decode accepts.
module instr_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    input  logic             mem_ack,
    input  logic [31:0]      mem_rdata,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [31:0]      instr,
    output logic [31:0]      instr_pc,
    output logic [31:0]      pc_plus4,
    input  logic             next_pc_valid,
    input  logic [31:0]      next_pc,
    output logic             misalign,
    output logic [CNT_W-1:0] retired_cnt
);

    fetch_state_t state;
    fetch_state_t state_next;
    logic [31:0]  pc;
    logic         ack_take;
    logic         accept;

    // The held instruction's address feeds the adder, so pc_plus4 stays
    // stable for the branch mux for as long as the instruction is held.
    instr_fetch_unit_pc_adder u_pc_adder (
        .pc       (instr_pc),
        .pc_plus4 (pc_plus4)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; req/valid follow the state directly,
    // so an ack is only ever honoured while a request is actually outstanding.
    always_comb begin
        state_next  = state;
        mem_req     = 1'b0;
        instr_valid = 1'b0;
        ack_take    = 1'b0;
        accept      = 1'b0;
        case (state)
            FETCH: begin
                state_next = WAIT;
            end
            WAIT: begin
                mem_req  = 1'b1;
                ack_take = mem_ack;
                if (mem_ack) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                accept      = instr_ready;
                if (instr_ready) begin
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // PC, fetch address, captured instruction, misalign pulse and retire counter.
    // The PC is kept word-aligned at all times, so mem_addr needs no masking.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= {RESET_PC[31:2], 2'b00};
            mem_addr    <= 32'h0000_0000;
            instr       <= 32'h0000_0000;
            instr_pc    <= 32'h0000_0000;
            misalign    <= 1'b0;
            retired_cnt <= '0;
        end else begin
            misalign <= 1'b0;
            if (state == FETCH) begin
                mem_addr <= pc;
            end
            if (ack_take) begin
                instr    <= mem_rdata;
                instr_pc <= pc;
            end
            if (accept) begin
                retired_cnt <= retired_cnt + CNT_W'(1);
                if (next_pc_valid) begin
                    pc       <= {next_pc[31:2], 2'b00};
                    misalign <= (next_pc[1:0] != 2'b00);
                end else begin
                    pc <= pc_plus4;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a table of fetch transactions
// (memory latency, decode stall, redirect, expected fetch address/misalign)
// plus a hand sequence for reset in the middle of a memory wait.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;
    logic        next_pc_valid;
    logic [31:0] next_pc;
    logic        misalign;
    logic [15:0] retired_cnt;

    instr_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .pc_plus4      (pc_plus4),
        .next_pc_valid (next_pc_valid),
        .next_pc       (next_pc),
        .misalign      (misalign),
        .retired_cnt   (retired_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ack_dly;
        int          rdy_dly;
        bit          nv;
        logic [31:0] npc;
        logic [31:0] exp_addr;
        bit          exp_mis;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } exp_t;

    vec_t        vecs [11];
    exp_t        sb [$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_acc_cyc = 0;
    logic [15:0] exp_cnt = 16'd0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h8C3F_5A00;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic run_instr(input vec_t v, input int idx);
        exp_t e;
        bit   seen;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (mem_req) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL req_timeout vec=%0d actual mem_req=0 required=1", idx);
            return;
        end
        chk("fetch_addr", mem_addr, v.exp_addr);
        // memory stalls; ready/redirect asserted here must be ignored
        for (int d = 0; d < v.ack_dly; d++) begin
            mem_ack       = 1'b0;
            instr_ready   = 1'b1;
            next_pc_valid = 1'b1;
            next_pc       = $urandom;
            step();
            chk("wait_req", 32'(mem_req), 32'd1);
            chk("wait_addr", mem_addr, v.exp_addr);
            chk("wait_valid", 32'(instr_valid), 32'd0);
            chk("wait_cnt", 32'(retired_cnt), 32'(exp_cnt));
        end
        instr_ready   = 1'b0;
        next_pc_valid = 1'b0;
        mem_ack       = 1'b1;
        mem_rdata     = word_at(v.exp_addr);
        e.instr = word_at(v.exp_addr);
        e.pc    = v.exp_addr;
        e.pc4   = v.exp_addr + 32'd4;
        sb.push_back(e);
        step();
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        chk("valid_rise", 32'(instr_valid), 32'd1);
        chk("req_drop", 32'(mem_req), 32'd0);
        // decode stalls; stray acks with garbage data must not disturb the word
        for (int r = 0; r < v.rdy_dly; r++) begin
            mem_ack     = 1'b1;
            mem_rdata   = $urandom;
            instr_ready = 1'b0;
            step();
            chk("hold_valid", 32'(instr_valid), 32'd1);
            chk("hold_req", 32'(mem_req), 32'd0);
            chk("hold_instr", instr, sb[0].instr);
            chk("hold_pc", instr_pc, sb[0].pc);
        end
        mem_ack = 1'b0;
        e = sb.pop_front();
        chk("instr", instr, e.instr);
        chk("instr_pc", instr_pc, e.pc);
        chk("pc_plus4", pc_plus4, e.pc4);
        instr_ready   = 1'b1;
        next_pc_valid = v.nv;
        next_pc       = v.npc;
        step();
        last_acc_cyc = cyc;
        exp_cnt      = exp_cnt + 16'd1;
        instr_ready   = 1'b0;
        next_pc_valid = 1'b0;
        next_pc       = $urandom;
        chk("accept_valid", 32'(instr_valid), 32'd0);
        chk("retired_cnt", 32'(retired_cnt), 32'(exp_cnt));
        chk("misalign", 32'(misalign), 32'(v.exp_mis));
        step();
        chk("misalign_pulse", 32'(misalign), 32'd0);
    endtask

    task automatic chk_reset_values();
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_cnt", 32'(retired_cnt), 32'd0);
    endtask

    initial begin
        //                ack rdy nv    npc            fetch addr     mis
        vecs[0]  = '{0, 0, 1'b0, 32'h0000_0000, 32'h0000_0004, 1'b0};
        vecs[1]  = '{0, 0, 1'b0, 32'h0000_0000, 32'h0000_0008, 1'b0};
        vecs[2]  = '{0, 0, 1'b1, 32'h0000_0040, 32'h0000_000C, 1'b0};
        vecs[3]  = '{3, 0, 1'b0, 32'h0000_0000, 32'h0000_0040, 1'b0};
        vecs[4]  = '{0, 4, 1'b0, 32'h0000_0000, 32'h0000_0044, 1'b0};
        vecs[5]  = '{1, 2, 1'b1, 32'h0000_0042, 32'h0000_0048, 1'b1};
        vecs[6]  = '{0, 0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0040, 1'b1};
        vecs[7]  = '{2, 1, 1'b0, 32'h0000_0000, 32'hFFFF_FFFC, 1'b0};
        vecs[8]  = '{0, 0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[9]  = '{0, 0, 1'b1, 32'h0000_0100, 32'h0000_0004, 1'b0};
        vecs[10] = '{0, 0, 1'b0, 32'h0000_0000, 32'h0000_0100, 1'b0};

        reset         = 1'b1;
        mem_ack       = 1'b0;
        mem_rdata     = 32'h0;
        instr_ready   = 1'b0;
        next_pc_valid = 1'b0;
        next_pc       = 32'h0;
        step();
        step();
        step();
        chk_reset_values();
        reset = 1'b0;
        cyc   = 0;

        for (int i = 0; i < 11; i++) begin
            run_instr(vecs[i], i);
            if (i == 2) begin
                chk("three_in_9_cycles", 32'(last_acc_cyc), 32'd9);
            end
        end

        // reset while a request is outstanding, with an ack arriving during reset
        chk("pre_reset_req", 32'(mem_req), 32'd1);
        reset     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        step();
        step();
        chk_reset_values();
        reset = 1'b0;
        cyc   = 0;
        step();
        chk("post_rst_req", 32'(mem_req), 32'd1);
        chk("post_rst_addr", mem_addr, 32'h0000_0004);
        chk("post_rst_valid", 32'(instr_valid), 32'd0);
        mem_ack = 1'b0;
        step();
        chk("no_late_ack_valid", 32'(instr_valid), 32'd0);
        chk("no_late_ack_req", 32'(mem_req), 32'd1);
        exp_cnt = 16'd0;
        sb.delete();
        run_instr('{0, 0, 1'b0, 32'h0, 32'h0000_0004, 1'b0}, 100);
        run_instr('{1, 1, 1'b0, 32'h0, 32'h0000_0008, 1'b0}, 101);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always ends on its own.
    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

endmodule
